recv_addr_arbiter: RTL

RECV_ADDR_ARBITER -- requirements
Module: recv_addr_arbiter

---
 rtl/recv_addr_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/recv_addr_arbiter.sv
// ---------------------------------------------------------------------------
// recv_addr_arbiter
//   Round-robin arbiter for four requesters sharing one 8-bit address path
//   into a Nios input port.
//   A winner's address is latched and held stable for SETUP_CYC cycles.
//   addr_valid is then raised until software acknowledges, or until TIMEOUT
//   cycles pass.
//   The block waits for ack_in to drop before returning to IDLE.
//
// Parameters
//   TIMEOUT    max cycles addr_valid stays high without ack (1..65535)
//   SETUP_CYC  cycles addr_out is stable before addr_valid rises (1..15)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   req[3:0]     level requests; requester i drops req[i] on grant[i]
//   addr_in[31:0] requester i address on addr_in[8i+7:8i]
//   ack_in       level acknowledge from software, synchronous to clk
//   err_clr      one-cycle pulse clearing timeout_err
//   grant[3:0]   one-hot, one-cycle pulse: request accepted, address latched
//   addr_out[7:0] address presented to the input port
//   addr_valid   presentation strobe
//   busy         high whenever the FSM is not IDLE
//   timeout_err  sticky flag: a presentation was aborted without ack
// ---------------------------------------------------------------------------
module recv_addr_arbiter #(
    parameter int TIMEOUT   = 1023,
    parameter int SETUP_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [31:0] addr_in,
    input  logic        ack_in,
    input  logic        err_clr,
    output logic [3:0]  grant,
    output logic [7:0]  addr_out,
    output logic        addr_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETUP    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);

    logic [1:0]  state;
    logic [3:0]  setup_cnt;
    logic [15:0] wait_cnt;
    logic [1:0]  last_grant;
    logic [1:0]  winner;
    logic [7:0]  addr_sel;

    // Rotate the request vector so bit 0 is the requester just after the
    // last grant, take the lowest set bit, then undo the rotation.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] off;
        dbl = {r, r} >> ({1'b0, last} + 3'd1);
        rot = dbl[3:0];
        off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) off = 2'(k);
        end
        return last + 2'd1 + off;
    endfunction

    always_comb begin
        winner   = rr_pick(req, last_grant);
        addr_sel = addr_in[{winner, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            grant       <= 4'b0000;
            addr_out    <= 8'h00;
            addr_valid  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            setup_cnt   <= 4'd0;
            wait_cnt    <= 16'd0;
            last_grant  <= 2'd3;
        end else begin
            grant <= 4'b0000;
            // A timeout raised below in the same cycle overrides this clear.
            if (err_clr) timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant      <= 4'b0001 << winner;
                        addr_out   <= addr_sel;
                        last_grant <= winner;
                        setup_cnt  <= SETUP_LAST;
                        busy       <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt == 4'd0) begin
                        addr_valid <= 1'b1;
                        wait_cnt   <= 16'd0;
                        state      <= ST_WAIT_ACK;
                    end else begin
                        setup_cnt <= setup_cnt - 4'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    // ack takes priority over a timeout on the same cycle
                    if (ack_in) begin
                        addr_valid <= 1'b0;
                        state      <= ST_RELEASE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        addr_valid  <= 1'b0;
                        state       <= ST_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_in) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
